// File: rtl/producto_escalar_param.sv
// Streaming dot-product engine. Operand pairs arrive over a valid/ready input,
// are multiplied into a registered product stage and then summed into a
// configurable-width accumulator (signed/unsigned, wrap or saturate). The
// result is offered on a valid/ready output.
module producto_escalar_param #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1),
  parameter int SIGNED   = 0,
  parameter int SATURATE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_length,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [ACC_W-1:0]  o_result,
  output logic              o_overflow,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy
);

  localparam int PW = 2 * DATA_W;
  localparam bit IS_SIGNED = (SIGNED != 0);
  localparam bit IS_SAT    = (SATURATE != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [ACC_W-1:0] MAX_U = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] MAX_S = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_S = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic [PW-1:0]    r_prod;
  logic             r_prod_vld;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_start_ok;
  logic [LEN_W-1:0] w_len_clamped;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_prod;
  logic [ACC_W:0]   w_sum;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_acc_next;

  assign o_in_ready  = (r_state == ST_RUN);
  assign o_out_valid = (r_state == ST_DONE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_result    = r_acc;
  assign o_overflow  = r_ovf;

  assign w_accept      = o_in_ready & i_in_valid;
  assign w_last        = (r_count == (r_len - LEN_W'(1)));
  assign w_start_ok    = (r_state == ST_IDLE) & i_start;
  assign w_len_clamped = (i_length > MAX_LEN_L) ? MAX_LEN_L : i_length;

  // Extending both operands to the full product width first lets one plain
  // multiplier produce the correct low 2*DATA_W bits in either signedness.
  assign w_a_ext = {{DATA_W{IS_SIGNED & i_a[DATA_W-1]}}, i_a};
  assign w_b_ext = {{DATA_W{IS_SIGNED & i_b[DATA_W-1]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // One extra guard bit makes the carry-out / sign-change visible.
  assign w_sum = {IS_SIGNED & r_acc[ACC_W-1], r_acc}
               + {{(ACC_W + 1 - PW){IS_SIGNED & r_prod[PW-1]}}, r_prod};

  // Detect range overflow of the addition and pick the wrapped or clamped value.
  always_comb begin
    w_add_ovf  = 1'b0;
    w_acc_next = w_sum[ACC_W-1:0];
    if (IS_SIGNED) begin
      w_add_ovf = w_sum[ACC_W] ^ w_sum[ACC_W-1];
      if (w_add_ovf && IS_SAT) begin
        w_acc_next = w_sum[ACC_W] ? MIN_S : MAX_S;
      end
    end else begin
      w_add_ovf = w_sum[ACC_W];
      if (w_add_ovf && IS_SAT) begin
        w_acc_next = MAX_U;
      end
    end
  end

  // Control FSM: vector length, accepted-pair count and state transitions.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_len   <= w_len_clamped;
            r_count <= '0;
            r_state <= (w_len_clamped == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_count <= r_count + LEN_W'(1);
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: r_state <= ST_DONE;
        default: begin
          if (i_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Product register: loads on every accepted pair, flagged for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod_vld <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
      end
    end
  end

  // Accumulator and sticky overflow: cleared by an accepted start, updated
  // one cycle after each product load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_start_ok) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_prod_vld) begin
      r_acc <= w_acc_next;
      r_ovf <= r_ovf | w_add_ovf;
    end
  end

endmodule
